lcd_4bit_writer: RTL and testbench

HD44780-compatible character-LCD transmitter for the comprocboard_9k top level. It accepts one LCD command or data byte per valid/ready handshake and drives the board's `lcd_rs`, `lcd_rw`, `lcd_e` and `lcd_db` pins in 4-bit mode, with programmable setup, enable-pulse, hold and execution delays. Upstream is the CPU's memory-mapped LCD register; downstream is the LCD pins of `top`. A nibble-only mode supports the 8-bit-mode wake-up writes of the power-on init sequence.

---
 rtl/lcd_4bit_writer_if.sv | 27 ++
 rtl/lcd_4bit_writer.sv | 171 +++++++++++++++++
 tb/tb_lcd_4bit_writer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_4bit_writer_if.sv
// Request channel into the LCD writer: one command/data byte per valid/ready handshake.
interface lcd_4bit_writer_if;
  logic       s_valid;
  logic       s_ready;
  logic       s_rs;
  logic [7:0] s_data;
  logic       s_nibble_only;
  logic       s_long;

  modport master (
    output s_valid,
    output s_rs,
    output s_data,
    output s_nibble_only,
    output s_long,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_rs,
    input  s_data,
    input  s_nibble_only,
    input  s_long,
    output s_ready
  );
endinterface

// File: rtl/lcd_4bit_writer.sv
// HD44780-compatible 4-bit-mode LCD transmitter. Sends one byte as two strobed
// nibbles (or a single nibble for the 8-bit wake-up writes), then waits out the
// controller's execution time before accepting the next request.
module lcd_4bit_writer #(
  parameter int SETUP_CYCLES      = 2,
  parameter int E_PULSE_CYCLES    = 12,
  parameter int HOLD_CYCLES       = 2,
  parameter int NIBBLE_GAP_CYCLES = 27,
  parameter int EXEC_CYCLES       = 1080,
  parameter int EXEC_LONG_CYCLES  = 44280
) (
  input  logic               clock,
  input  logic               reset,
  lcd_4bit_writer_if.slave   s,
  output logic               busy,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_e,
  output logic [3:0]         lcd_db
);

  localparam int MAX_A = (SETUP_CYCLES > E_PULSE_CYCLES) ? SETUP_CYCLES : E_PULSE_CYCLES;
  localparam int MAX_B = (HOLD_CYCLES > NIBBLE_GAP_CYCLES) ? HOLD_CYCLES : NIBBLE_GAP_CYCLES;
  localparam int MAX_C = (EXEC_CYCLES > EXEC_LONG_CYCLES) ? EXEC_CYCLES : EXEC_LONG_CYCLES;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > MAX_D) ? MAX_C : MAX_D;
  localparam int CW    = $clog2(MAX_P) + 1;

  // Counter reload values: a state lasting N cycles starts at N-1 and exits at 0.
  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] L_E     = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] L_EX    = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] L_EXL   = CW'(EXEC_LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_GAP,
    ST_EXEC
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          idx_q, idx_d;
  logic [3:0]    data_lo_q, data_lo_d;
  logic          nib_q, nib_d;
  logic          long_q, long_d;
  logic          ready_q, ready_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_e_q, lcd_e_d;
  logic [3:0]    lcd_db_q, lcd_db_d;

  logic          cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  // State, shared delay counter, latched request and registered pin drivers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 1'b0;
      data_lo_q <= 4'h0;
      nib_q     <= 1'b0;
      long_q    <= 1'b0;
      ready_q   <= 1'b0;
      lcd_rs_q  <= 1'b0;
      lcd_e_q   <= 1'b0;
      lcd_db_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_lo_q <= data_lo_d;
      nib_q     <= nib_d;
      long_q    <= long_d;
      ready_q   <= ready_d;
      lcd_rs_q  <= lcd_rs_d;
      lcd_e_q   <= lcd_e_d;
      lcd_db_q  <= lcd_db_d;
    end
  end

  // Next-state and next-output logic; pin values are computed one edge ahead so every output is a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : (cnt_q - CW'(1));
    idx_d     = idx_q;
    data_lo_d = data_lo_q;
    nib_d     = nib_q;
    long_d    = long_q;
    ready_d   = 1'b0;
    lcd_rs_d  = lcd_rs_q;
    lcd_e_d   = 1'b0;
    lcd_db_d  = lcd_db_q;

    case (state_q)
      ST_IDLE: begin
        // Ready rises one cycle after re-entering IDLE, guaranteeing an idle gap between transfers.
        ready_d = 1'b1;
        cnt_d   = cnt_q;
        if (ready_q && s.s_valid) begin
          ready_d   = 1'b0;
          state_d   = ST_SETUP;
          cnt_d     = L_SETUP;
          idx_d     = 1'b0;
          data_lo_d = s.s_data[3:0];
          nib_d     = s.s_nibble_only;
          long_d    = s.s_long;
          lcd_rs_d  = s.s_rs;
          lcd_db_d  = s.s_data[7:4];
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_E_HIGH;
          cnt_d   = L_E;
          lcd_e_d = 1'b1;
        end
      end
      ST_E_HIGH: begin
        lcd_e_d = 1'b1;
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = L_HOLD;
          lcd_e_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          if (!idx_q && !nib_q) begin
            state_d = ST_GAP;
            cnt_d   = L_GAP;
          end else begin
            state_d = ST_EXEC;
            cnt_d   = long_q ? L_EXL : L_EX;
          end
        end
      end
      ST_GAP: begin
        // The low nibble goes onto the bus only now, well clear of the previous strobe.
        if (cnt_zero) begin
          state_d  = ST_SETUP;
          cnt_d    = L_SETUP;
          idx_d    = 1'b1;
          lcd_db_d = data_lo_q;
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign s.s_ready = ready_q;
  assign busy      = ~ready_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_db    = lcd_db_q;

endmodule

// File: tb/tb_lcd_4bit_writer.sv
// Directed bench for lcd_4bit_writer with short timing parameters.
module tb_lcd_4bit_writer;

  logic       clock;
  logic       reset;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_db;

  lcd_4bit_writer_if bus ();

  lcd_4bit_writer #(
    .SETUP_CYCLES      (1),
    .E_PULSE_CYCLES    (3),
    .HOLD_CYCLES       (1),
    .NIBBLE_GAP_CYCLES (4),
    .EXEC_CYCLES       (8),
    .EXEC_LONG_CYCLES  (20)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .s      (bus),
    .busy   (busy),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_e  (lcd_e),
    .lcd_db (lcd_db)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: records DB/RS at each E rise and the width of each E pulse.
  logic [3:0] q_db[$];
  logic       q_rs[$];
  int         q_w[$];
  logic       e_prev = 1'b0;
  int         cur_w  = 0;
  logic [3:0] s_db   = 4'h0;
  logic       s_rs   = 1'b0;
  int         stable_err = 0;
  int         rw_err     = 0;

  always @(negedge clock) begin
    if (lcd_rw !== 1'b0) rw_err <= rw_err + 1;
    if (lcd_e && !e_prev) begin
      q_db.push_back(lcd_db);
      q_rs.push_back(lcd_rs);
      cur_w <= 1;
      s_db  <= lcd_db;
      s_rs  <= lcd_rs;
    end else if (lcd_e) begin
      cur_w <= cur_w + 1;
      if (lcd_db !== s_db || lcd_rs !== s_rs) stable_err <= stable_err + 1;
    end else if (e_prev) begin
      q_w.push_back(cur_w);
    end
    e_prev <= lcd_e;
  end

  task automatic clear_mon();
    q_db.delete();
    q_rs.delete();
    q_w.delete();
  endtask

  // Counts edges after acceptance until s_ready is seen high again.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!bus.s_ready && cyc < 200);
  endtask

  task automatic send(input string tag, input logic rs, input logic [7:0] d,
                      input logic nib, input logic lng, input int exp_lat);
    int n;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    clear_mon();
    @(negedge clock);
    bus.s_valid       = 1'b1;
    bus.s_rs          = rs;
    bus.s_data        = d;
    bus.s_nibble_only = nib;
    bus.s_long        = lng;
    @(posedge clock);
    #1;
    bus.s_valid = 1'b0;
    check({tag, "_ready_fell"}, bus.s_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_setup_db"}, lcd_db, d[7:4]);
    check({tag, "_setup_rs"}, lcd_rs, rs);
    wait_ready(n);
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic check_pulse(input string tag, input int i, input logic [3:0] db, input logic rs);
    if (i < q_db.size()) begin
      check({tag, "_db"}, q_db[i], db);
      check({tag, "_rs"}, q_rs[i], rs);
    end else begin
      check({tag, "_missing"}, 32'(q_db.size()), 32'(i + 1));
    end
    if (i < q_w.size()) check({tag, "_width"}, q_w[i], 3);
    else check({tag, "_width_missing"}, 32'(q_w.size()), 32'(i + 1));
  endtask

  initial begin
    int n;
    bus.s_valid       = 1'b0;
    bus.s_rs          = 1'b0;
    bus.s_data        = 8'h00;
    bus.s_nibble_only = 1'b0;
    bus.s_long        = 1'b0;
    reset             = 1'b0;

    // Reset then idle
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_ready", bus.s_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_outs", {lcd_rs, lcd_rw, lcd_e, lcd_db}, 7'h00);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("idle_ready", bus.s_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_outs", {lcd_rs, lcd_rw, lcd_e, lcd_db}, 7'h00);

    // Data byte 0x41
    send("data41", 1'b1, 8'h41, 1'b0, 1'b0, 23);
    check("data41_npulse", 32'(q_db.size()), 2);
    check_pulse("data41_p0", 0, 4'h4, 1'b1);
    check_pulse("data41_p1", 1, 4'h1, 1'b1);
    check("data41_rs_hold", lcd_rs, 1'b1);
    check("data41_db_hold", lcd_db, 4'h1);

    // Nibble-only wake-up
    send("nib30", 1'b0, 8'h30, 1'b1, 1'b0, 14);
    check("nib30_npulse", 32'(q_db.size()), 1);
    check_pulse("nib30_p0", 0, 4'h3, 1'b0);

    // Clear display (long exec)
    send("clr", 1'b0, 8'h01, 1'b0, 1'b1, 35);
    check("clr_npulse", 32'(q_db.size()), 2);
    check_pulse("clr_p0", 0, 4'h0, 1'b0);
    check_pulse("clr_p1", 1, 4'h1, 1'b0);

    // Back-to-back with s_valid held high
    clear_mon();
    @(negedge clock);
    bus.s_valid       = 1'b1;
    bus.s_rs          = 1'b1;
    bus.s_data        = 8'h48;
    bus.s_nibble_only = 1'b0;
    bus.s_long        = 1'b0;
    @(posedge clock);
    #1;
    check("b2b_first_accept", bus.s_ready, 1'b0);
    bus.s_data = 8'h69;
    wait_ready(n);
    check("b2b_first_latency", n, 23);
    @(posedge clock);
    #1;
    check("b2b_second_accept", bus.s_ready, 1'b0);
    check("b2b_second_db", lcd_db, 4'h6);
    bus.s_valid = 1'b0;
    wait_ready(n);
    check("b2b_second_latency", n, 23);
    check("b2b_npulse", 32'(q_db.size()), 4);
    check_pulse("b2b_p0", 0, 4'h4, 1'b1);
    check_pulse("b2b_p1", 1, 4'h8, 1'b1);
    check_pulse("b2b_p2", 2, 4'h6, 1'b1);
    check_pulse("b2b_p3", 3, 4'h9, 1'b1);
    check("db_stable_under_e", stable_err, 0);
    check("rw_always_low", rw_err, 0);

    // Reset during first E pulse
    @(negedge clock);
    bus.s_valid = 1'b1;
    bus.s_rs    = 1'b1;
    bus.s_data  = 8'h5A;
    @(posedge clock);
    #1;
    bus.s_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("mid_e_reached", lcd_e, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_outs", {lcd_rs, lcd_rw, lcd_e, lcd_db}, 7'h00);
    check("mid_rst_ready", bus.s_ready, 1'b0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_mon();
    repeat (40) @(posedge clock);
    #1;
    check("mid_no_pulse", 32'(q_db.size()), 0);
    check("mid_ready_back", bus.s_ready, 1'b1);
    check("mid_outs_idle", {lcd_rs, lcd_e, lcd_db}, 6'h00);

    // Block works normally after the mid-transfer reset
    send("post", 1'b1, 8'hC7, 1'b0, 1'b0, 23);
    check_pulse("post_p0", 0, 4'hC, 1'b1);
    check_pulse("post_p1", 1, 4'h7, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
